// File: rtl/alu_issue_skid_reg.sv
// Two-entry skid register between the ALU issue port and ALU execute; tracks branch masks and kills wrong-path bundles.
// Latency: one cycle from accept to o_valid when empty; sustains one bundle per cycle.
// Backpressure: o_ready = !skid_valid (registered), so there is no combinational path from i_ready.
module alu_issue_skid_reg #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int OP_W   = 4,
    parameter int SEL1_W = 1,
    parameter int SEL2_W = 1,
    parameter int TAG_W  = 6,
    parameter int BRM_W  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [OP_W-1:0]   i_op,
    input  logic [SEL1_W-1:0] i_src1_sel,
    input  logic [SEL2_W-1:0] i_src2_sel,
    input  logic [DATA_W-1:0] i_rs1,
    input  logic [DATA_W-1:0] i_rs2,
    input  logic [DATA_W-1:0] i_imm,
    input  logic [PC_W-1:0]   i_pc,
    input  logic [TAG_W-1:0]  i_rob_tag,
    input  logic [BRM_W-1:0]  i_br_mask,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [OP_W-1:0]   o_op,
    output logic [SEL1_W-1:0] o_src1_sel,
    output logic [SEL2_W-1:0] o_src2_sel,
    output logic [DATA_W-1:0] o_rs1,
    output logic [DATA_W-1:0] o_rs2,
    output logic [DATA_W-1:0] o_imm,
    output logic [PC_W-1:0]   o_pc,
    output logic [TAG_W-1:0]  o_rob_tag,
    output logic [BRM_W-1:0]  o_br_mask,
    input  logic              i_br_res_valid,
    input  logic [BRM_W-1:0]  i_br_res_tag,
    input  logic              i_br_mispredict,
    input  logic              i_flush_all
);

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [SEL1_W-1:0] src1_sel;
        logic [SEL2_W-1:0] src2_sel;
        logic [DATA_W-1:0] rs1;
        logic [DATA_W-1:0] rs2;
        logic [DATA_W-1:0] imm;
        logic [PC_W-1:0]   pc;
        logic [TAG_W-1:0]  rob_tag;
        logic [BRM_W-1:0]  br_mask;
    } bundle_t;

    bundle_t head_q, skid_q, head_d, skid_d, in_b;
    logic    head_vld_q, skid_vld_q, head_vld_d, skid_vld_d;

    logic             mispred;
    logic [BRM_W-1:0] res_clr;
    logic             head_kill, skid_kill, in_kill;
    logic             head_live, skid_live, in_live;
    logic             accept, head_free;

    assign mispred = i_br_res_valid & i_br_mispredict;
    assign res_clr = (i_br_res_valid & ~i_br_mispredict) ? i_br_res_tag : '0;

    assign head_kill = mispred & |(head_q.br_mask & i_br_res_tag);
    assign skid_kill = mispred & |(skid_q.br_mask & i_br_res_tag);
    assign in_kill   = mispred & |(i_br_mask & i_br_res_tag);

    // Flush overrides everything: nothing stored or incoming survives it.
    assign head_live = head_vld_q & ~head_kill & ~i_flush_all;
    assign skid_live = skid_vld_q & ~skid_kill & ~i_flush_all;
    assign accept    = i_valid & o_ready;
    assign in_live   = accept & ~in_kill & ~i_flush_all;

    // Head slot is vacated this cycle if it is empty, killed, or handing off.
    assign head_free = ~head_live | i_ready;

    always_comb begin
        in_b.op       = i_op;
        in_b.src1_sel = i_src1_sel;
        in_b.src2_sel = i_src2_sel;
        in_b.rs1      = i_rs1;
        in_b.rs2      = i_rs2;
        in_b.imm      = i_imm;
        in_b.pc       = i_pc;
        in_b.rob_tag  = i_rob_tag;
        in_b.br_mask  = i_br_mask & ~res_clr;
    end

    always_comb begin
        head_d         = head_q;
        head_d.br_mask = head_q.br_mask & ~res_clr;
        skid_d         = skid_q;
        skid_d.br_mask = skid_q.br_mask & ~res_clr;
        head_vld_d     = head_live;
        skid_vld_d     = skid_live;
        if (head_free) begin
            if (skid_live) begin
                head_d     = skid_q;
                head_d.br_mask = skid_q.br_mask & ~res_clr;
                head_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else if (in_live) begin
                head_d     = in_b;
                head_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else begin
                head_vld_d = 1'b0;
                skid_vld_d = 1'b0;
            end
        end else if (in_live) begin
            // Accept implies skid was empty, so overflow lands in skid.
            skid_d     = in_b;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head_q     <= '0;
            skid_q     <= '0;
            head_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            skid_q     <= skid_d;
            head_vld_q <= head_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign o_ready    = ~skid_vld_q;
    assign o_valid    = head_live;
    assign o_op       = head_q.op;
    assign o_src1_sel = head_q.src1_sel;
    assign o_src2_sel = head_q.src2_sel;
    assign o_rs1      = head_q.rs1;
    assign o_rs2      = head_q.rs2;
    assign o_imm      = head_q.imm;
    assign o_pc       = head_q.pc;
    assign o_rob_tag  = head_q.rob_tag;
    assign o_br_mask  = head_q.br_mask & ~res_clr;

endmodule

// File: tb/tb_alu_issue_skid_reg.sv
// Directed bench for alu_issue_skid_reg: streaming, stall, kill, resolve, flush and reset scenarios.
module tb_alu_issue_skid_reg;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [3:0]  i_op;
    logic [0:0]  i_src1_sel;
    logic [0:0]  i_src2_sel;
    logic [31:0] i_rs1, i_rs2, i_imm, i_pc;
    logic [5:0]  i_rob_tag;
    logic [3:0]  i_br_mask;
    logic        o_valid;
    logic        i_ready;
    logic [3:0]  o_op;
    logic [0:0]  o_src1_sel;
    logic [0:0]  o_src2_sel;
    logic [31:0] o_rs1, o_rs2, o_imm, o_pc;
    logic [5:0]  o_rob_tag;
    logic [3:0]  o_br_mask;
    logic        i_br_res_valid;
    logic [3:0]  i_br_res_tag;
    logic        i_br_mispredict;
    logic        i_flush_all;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 i_clk = ~i_clk;

    alu_issue_skid_reg dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_src1_sel(i_src1_sel), .i_src2_sel(i_src2_sel),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm), .i_pc(i_pc),
        .i_rob_tag(i_rob_tag), .i_br_mask(i_br_mask),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_op(o_op), .o_src1_sel(o_src1_sel), .o_src2_sel(o_src2_sel),
        .o_rs1(o_rs1), .o_rs2(o_rs2), .o_imm(o_imm), .o_pc(o_pc),
        .o_rob_tag(o_rob_tag), .o_br_mask(o_br_mask),
        .i_br_res_valid(i_br_res_valid), .i_br_res_tag(i_br_res_tag),
        .i_br_mispredict(i_br_mispredict), .i_flush_all(i_flush_all)
    );

    // Inputs change 1 time unit after the rising edge; checks happen 2 units later.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input int id, input logic [3:0] mask);
        i_valid    = v;
        i_op       = id[3:0];
        i_src1_sel = id[0];
        i_src2_sel = id[1];
        i_rs1      = 32'h100 + id;
        i_rs2      = 32'h200 + id;
        i_imm      = 32'h300 + id;
        i_pc       = 32'h1000 + id * 4;
        i_rob_tag  = id[5:0];
        i_br_mask  = mask;
    endtask

    task automatic resolve(input logic v, input logic mp, input logic [3:0] tag);
        i_br_res_valid  = v;
        i_br_mispredict = mp;
        i_br_res_tag    = tag;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        drive(1'b0, 0, 4'b0000);
        resolve(1'b0, 1'b0, 4'b0000);
        i_ready     = 1'b0;
        i_flush_all = 1'b0;
        step();
        step();
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #2;
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", o_valid); end
        n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", o_ready); end
        n_checks++; if (o_rs1 !== 32'h0 || o_pc !== 32'h0 || o_op !== 4'h0) begin n_fail++; $display("FAIL reset_data rs1=%h pc=%h op=%h exp 0", o_rs1, o_pc, o_op); end
    endtask

    task automatic test_stream();
        do_reset();
        i_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            drive(c < 8, c + 1, 4'b0000);
            #2;
            n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready c=%0d got %b exp 1", c, o_ready); end
            if (c >= 1 && c <= 8) begin
                n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid c=%0d got %b exp 1", c, o_valid); end
                n_checks++; if (o_rs1 !== 32'h100 + c || o_pc !== 32'h1000 + c * 4 || o_rob_tag !== 6'(c)) begin
                    n_fail++; $display("FAIL stream_data c=%0d rs1=%h pc=%h tag=%0d exp id %0d", c, o_rs1, o_pc, o_rob_tag, c);
                end
            end else begin
                n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL stream_idle c=%0d got %b exp 0", c, o_valid); end
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1'b1, 40, 4'b0000); i_ready = 1'b0; step();
        drive(1'b1, 41, 4'b0000); #2;
        n_checks++; if (o_valid !== 1'b1 || o_rs1 !== 32'h128 || o_ready !== 1'b1) begin n_fail++; $display("FAIL stall1 v=%b rs1=%h rdy=%b exp 1/128/1", o_valid, o_rs1, o_ready); end
        step();
        drive(1'b1, 42, 4'b0000); #2;
        n_checks++; if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_rs1 !== 32'h128) begin n_fail++; $display("FAIL stall2 rdy=%b v=%b rs1=%h exp 0/1/128", o_ready, o_valid, o_rs1); end
        step();
        i_ready = 1'b1; #2;
        n_checks++; if (o_ready !== 1'b0 || o_rs1 !== 32'h128) begin n_fail++; $display("FAIL release0 rdy=%b rs1=%h exp 0/128", o_ready, o_rs1); end
        step(); #2;
        n_checks++; if (o_ready !== 1'b1 || o_valid !== 1'b1 || o_rs1 !== 32'h129) begin n_fail++; $display("FAIL release1 rdy=%b v=%b rs1=%h exp 1/1/129", o_ready, o_valid, o_rs1); end
        step();
        drive(1'b0, 0, 4'b0000); #2;
        n_checks++; if (o_valid !== 1'b1 || o_rs1 !== 32'h12a) begin n_fail++; $display("FAIL release2 v=%b rs1=%h exp 1/12a", o_valid, o_rs1); end
        step(); #2;
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL release_dup v=%b exp 0", o_valid); end
    endtask

    task automatic test_mispredict();
        do_reset();
        drive(1'b1, 10, 4'b0010); step();
        drive(1'b1, 11, 4'b0001); step();
        drive(1'b0, 0, 4'b0000); resolve(1'b1, 1'b1, 4'b0010); #2;
        n_checks++; if (o_valid !== 1'b0 || o_ready !== 1'b0) begin n_fail++; $display("FAIL kill_same v=%b rdy=%b exp 0/0", o_valid, o_ready); end
        step();
        resolve(1'b0, 1'b0, 4'b0000); #2;
        n_checks++; if (o_valid !== 1'b1 || o_rs1 !== 32'h10b || o_br_mask !== 4'b0001 || o_ready !== 1'b1) begin
            n_fail++; $display("FAIL kill_promote v=%b rs1=%h mask=%b rdy=%b exp 1/10b/0001/1", o_valid, o_rs1, o_br_mask, o_ready);
        end
        i_ready = 1'b1; step(); #2;
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL kill_drain v=%b exp 0", o_valid); end
        drive(1'b1, 12, 4'b1000); resolve(1'b1, 1'b1, 4'b1000); #2;
        n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL kill_in_ready got %b exp 1", o_ready); end
        step();
        drive(1'b0, 0, 4'b0000); resolve(1'b0, 1'b0, 4'b0000); #2;
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL kill_in_stored v=%b exp 0", o_valid); end
    endtask

    task automatic test_resolve();
        do_reset();
        drive(1'b1, 20, 4'b0110); step();
        drive(1'b1, 21, 4'b0100); resolve(1'b1, 1'b0, 4'b0100); #2;
        n_checks++; if (o_valid !== 1'b1 || o_br_mask !== 4'b0010) begin n_fail++; $display("FAIL resolve_same v=%b mask=%b exp 1/0010", o_valid, o_br_mask); end
        step();
        drive(1'b0, 0, 4'b0000); resolve(1'b0, 1'b0, 4'b0000); i_ready = 1'b1; #2;
        n_checks++; if (o_valid !== 1'b1 || o_rs1 !== 32'h114 || o_br_mask !== 4'b0010) begin n_fail++; $display("FAIL resolve_head v=%b rs1=%h mask=%b exp 1/114/0010", o_valid, o_rs1, o_br_mask); end
        step(); #2;
        n_checks++; if (o_valid !== 1'b1 || o_rs1 !== 32'h115 || o_br_mask !== 4'b0000) begin n_fail++; $display("FAIL resolve_skid v=%b rs1=%h mask=%b exp 1/115/0000", o_valid, o_rs1, o_br_mask); end
        step(); #2;
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL resolve_drain v=%b exp 0", o_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 30, 4'b0000); step();
        drive(1'b1, 31, 4'b0000); step();
        drive(1'b1, 32, 4'b0000); i_flush_all = 1'b1; #2;
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL flush_same v=%b exp 0", o_valid); end
        step();
        i_flush_all = 1'b0; drive(1'b0, 0, 4'b0000); #2;
        n_checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin n_fail++; $display("FAIL flush_next v=%b rdy=%b exp 0/1", o_valid, o_ready); end
        drive(1'b1, 33, 4'b0000); step();
        drive(1'b1, 34, 4'b0000); i_flush_all = 1'b1; #2;
        n_checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin n_fail++; $display("FAIL flush_occ1 rdy=%b v=%b exp 1/0", o_ready, o_valid); end
        step();
        i_flush_all = 1'b0; drive(1'b0, 0, 4'b0000); #2;
        n_checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_dropped v=%b rdy=%b exp 0/1", o_valid, o_ready); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1'b1, 50, 4'b0011); step();
        drive(1'b1, 51, 4'b0001); step();
        drive(1'b0, 0, 4'b0000); #2;
        n_checks++; if (o_ready !== 1'b0 || o_valid !== 1'b1) begin n_fail++; $display("FAIL mid_full rdy=%b v=%b exp 0/1", o_ready, o_valid); end
        i_rst = 1'b1; step();
        i_rst = 1'b0; #2;
        n_checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset v=%b rdy=%b exp 0/1", o_valid, o_ready); end
        n_checks++; if (o_rs1 !== 32'h0 || o_pc !== 32'h0 || o_br_mask !== 4'h0 || o_rob_tag !== 6'h0) begin
            n_fail++; $display("FAIL mid_reset_data rs1=%h pc=%h mask=%b tag=%0d exp 0", o_rs1, o_pc, o_br_mask, o_rob_tag);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_mispredict();
        test_resolve();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
